// File: rtl/pong_game_ctrl_if.sv
// ============================================================================
// Module : pong_game_ctrl_if
// Desc   : Frame strobe, player controls and game-state outputs of the Pong
//          frame-rate sequencer, bundled for the controller and its renderer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pong_game_ctrl_if;
    logic       i_frame;
    logic       i_start;
    logic       i_l_up;
    logic       i_l_dn;
    logic       i_r_up;
    logic       i_r_dn;
    logic [9:0] o_ball_x;
    logic [8:0] o_ball_y;
    logic [8:0] o_pad_l_y;
    logic [8:0] o_pad_r_y;
    logic [3:0] o_score_l;
    logic [3:0] o_score_r;
    logic [1:0] o_state;
    logic       o_game_over;

    modport master (
        output i_frame, i_start, i_l_up, i_l_dn, i_r_up, i_r_dn,
        input  o_ball_x, o_ball_y, o_pad_l_y, o_pad_r_y,
               o_score_l, o_score_r, o_state, o_game_over
    );

    modport slave (
        input  i_frame, i_start, i_l_up, i_l_dn, i_r_up, i_r_dn,
        output o_ball_x, o_ball_y, o_pad_l_y, o_pad_r_y,
               o_score_l, o_score_r, o_state, o_game_over
    );
endinterface

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// ============================================================================
// Module : pong_game_ctrl
// Desc   : Pong game sequencer; advances ball, paddles, scores and match state
//          once per video frame strobe. All outputs are registered.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pong_game_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 64,
    parameter int PAD_L_X      = 16,
    parameter int PAD_R_X      = 616,
    parameter int BALL_SPEED   = 2,
    parameter int PAD_SPEED    = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  wire logic        CLK,
    input  wire logic        RST_BTN,
    pong_game_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [10:0] c_ball_x0  = 11'((H_RES - BALL_SIZE) / 2);
    localparam logic [10:0] c_ball_y0  = 11'((V_RES - BALL_SIZE) / 2);
    localparam logic [10:0] c_pad_y0   = 11'((V_RES - PAD_H) / 2);
    localparam logic [10:0] c_pad_max  = 11'(V_RES - PAD_H);
    localparam logic [10:0] c_ball_ymx = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] c_face_l   = 11'(PAD_L_X + PAD_W);
    localparam logic [10:0] c_face_r   = 11'(PAD_R_X);
    localparam logic [10:0] c_hit_r_x  = 11'(PAD_R_X - BALL_SIZE);
    localparam logic [10:0] c_bsz      = 11'(BALL_SIZE);
    localparam logic [10:0] c_pad_h    = 11'(PAD_H);
    localparam logic [10:0] c_spd      = 11'(BALL_SPEED);
    localparam logic [10:0] c_pspd     = 11'(PAD_SPEED);
    localparam logic [10:0] c_h_res    = 11'(H_RES);
    localparam logic [10:0] c_v_res    = 11'(V_RES);
    localparam logic [3:0]  c_win      = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] c_serve = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    state_t           r_state;
    logic [9:0]       r_ball_x;
    logic [8:0]       r_ball_y;
    logic [8:0]       r_pad_l_y;
    logic [8:0]       r_pad_r_y;
    logic [3:0]       r_score_l;
    logic [3:0]       r_score_r;
    logic             r_dir_right;
    logic             r_dir_down;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [9:0]       w_ball_x_nxt;
    logic [8:0]       w_ball_y_nxt;
    logic [8:0]       w_pad_l_nxt;
    logic [8:0]       w_pad_r_nxt;
    logic [3:0]       w_score_l_nxt;
    logic [3:0]       w_score_r_nxt;
    logic             w_dir_right_nxt;
    logic             w_dir_down_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [10:0] w_bx;
    logic [10:0] w_by;
    logic [10:0] w_pl;
    logic [10:0] w_pr;
    logic [8:0]  w_y_step;
    logic        w_dy_step;
    logic        w_hit_l;
    logic        w_hit_r;
    logic        w_miss_l;
    logic        w_miss_r;
    logic [3:0]  w_score_l_inc;
    logic [3:0]  w_score_r_inc;
    logic [8:0]  w_pad_l_mv;
    logic [8:0]  w_pad_r_mv;

    // Clamp is checked before the subtraction so the paddle never wraps.
    function automatic logic [8:0] f_pad_step(input logic [10:0] y,
                                              input logic up, input logic dn);
        logic [8:0] v;
        v = 9'(y);
        if (up && !dn)
            v = (y < c_pspd) ? 9'd0 : 9'(y - c_pspd);
        else if (dn && !up)
            v = (y + c_pspd > c_pad_max) ? 9'(c_pad_max) : 9'(y + c_pspd);
        return v;
    endfunction

    assign w_bx = {1'b0, r_ball_x};
    assign w_by = {2'b00, r_ball_y};
    assign w_pl = {2'b00, r_pad_l_y};
    assign w_pr = {2'b00, r_pad_r_y};

    assign w_pad_l_mv = f_pad_step(w_pl, bus.i_l_up, bus.i_l_dn);
    assign w_pad_r_mv = f_pad_step(w_pr, bus.i_r_up, bus.i_r_dn);

    always_comb begin
        w_y_step  = r_dir_down ? 9'(w_by + c_spd) : 9'(w_by - c_spd);
        w_dy_step = r_dir_down;
        if (!r_dir_down && (w_by < c_spd)) begin
            w_y_step  = 9'd0;
            w_dy_step = 1'b1;
        end else if (r_dir_down && (w_by + c_bsz + c_spd > c_v_res)) begin
            w_y_step  = 9'(c_ball_ymx);
            w_dy_step = 1'b0;
        end
    end

    // Paddle collision uses the paddle positions from before this frame's move.
    assign w_hit_l = !r_dir_right && (w_bx >= c_face_l) && (w_bx - c_spd < c_face_l)
                     && (w_by + c_bsz > w_pl) && (w_by < w_pl + c_pad_h);
    assign w_hit_r = r_dir_right && (w_bx + c_bsz <= c_face_r)
                     && (w_bx + c_bsz + c_spd > c_face_r)
                     && (w_by + c_bsz > w_pr) && (w_by < w_pr + c_pad_h);
    assign w_miss_l = !r_dir_right && (w_bx < c_spd);
    assign w_miss_r = r_dir_right && (w_bx + c_bsz + c_spd > c_h_res);

    assign w_score_l_inc = r_score_l + 4'd1;
    assign w_score_r_inc = r_score_r + 4'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_ball_x_nxt    = r_ball_x;
        w_ball_y_nxt    = r_ball_y;
        w_pad_l_nxt     = r_pad_l_y;
        w_pad_r_nxt     = r_pad_r_y;
        w_score_l_nxt   = r_score_l;
        w_score_r_nxt   = r_score_r;
        w_dir_right_nxt = r_dir_right;
        w_dir_down_nxt  = r_dir_down;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (bus.i_start) begin
                    w_state_nxt   = S_SERVE;
                    w_score_l_nxt = 4'd0;
                    w_score_r_nxt = 4'd0;
                    w_ball_x_nxt  = 10'(c_ball_x0);
                    w_ball_y_nxt  = 9'(c_ball_y0);
                    w_pad_l_nxt   = 9'(c_pad_y0);
                    w_pad_r_nxt   = 9'(c_pad_y0);
                    w_cnt_nxt     = c_serve;
                end
            end
            S_SERVE: begin
                w_pad_l_nxt = w_pad_l_mv;
                w_pad_r_nxt = w_pad_r_mv;
                if (r_cnt != '0)
                    w_cnt_nxt = r_cnt - c_one;
                else
                    w_state_nxt = S_PLAY;
            end
            default: begin
                w_pad_l_nxt = w_pad_l_mv;
                w_pad_r_nxt = w_pad_r_mv;
                if (w_hit_l || w_hit_r) begin
                    w_ball_x_nxt    = w_hit_l ? 10'(c_face_l) : 10'(c_hit_r_x);
                    w_dir_right_nxt = w_hit_l;
                    w_ball_y_nxt    = w_y_step;
                    w_dir_down_nxt  = w_dy_step;
                end else if (w_miss_l || w_miss_r) begin
                    // Ball returns to centre heading toward whoever conceded.
                    w_ball_x_nxt    = 10'(c_ball_x0);
                    w_ball_y_nxt    = 9'(c_ball_y0);
                    w_dir_right_nxt = w_miss_r;
                    w_cnt_nxt       = c_serve;
                    w_state_nxt     = S_SERVE;
                    if (w_miss_l) begin
                        w_score_r_nxt = w_score_r_inc;
                        if (w_score_r_inc == c_win)
                            w_state_nxt = S_OVER;
                    end else begin
                        w_score_l_nxt = w_score_l_inc;
                        if (w_score_l_inc == c_win)
                            w_state_nxt = S_OVER;
                    end
                end else begin
                    w_ball_x_nxt   = r_dir_right ? 10'(w_bx + c_spd) : 10'(w_bx - c_spd);
                    w_ball_y_nxt   = w_y_step;
                    w_dir_down_nxt = w_dy_step;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_state     <= S_IDLE;
            r_ball_x    <= 10'(c_ball_x0);
            r_ball_y    <= 9'(c_ball_y0);
            r_pad_l_y   <= 9'(c_pad_y0);
            r_pad_r_y   <= 9'(c_pad_y0);
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_dir_right <= 1'b1;
            r_dir_down  <= 1'b1;
            r_cnt       <= '0;
        end else if (bus.i_frame) begin
            r_state     <= w_state_nxt;
            r_ball_x    <= w_ball_x_nxt;
            r_ball_y    <= w_ball_y_nxt;
            r_pad_l_y   <= w_pad_l_nxt;
            r_pad_r_y   <= w_pad_r_nxt;
            r_score_l   <= w_score_l_nxt;
            r_score_r   <= w_score_r_nxt;
            r_dir_right <= w_dir_right_nxt;
            r_dir_down  <= w_dir_down_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign bus.o_ball_x    = r_ball_x;
    assign bus.o_ball_y    = r_ball_y;
    assign bus.o_pad_l_y   = r_pad_l_y;
    assign bus.o_pad_r_y   = r_pad_r_y;
    assign bus.o_score_l   = r_score_l;
    assign bus.o_score_r   = r_score_r;
    assign bus.o_state     = r_state;
    assign bus.o_game_over = (r_state == S_OVER);

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// ============================================================================
// Module : tb_pong_game_ctrl
// Desc   : Self-checking bench for pong_game_ctrl: literal vector table for the
//          idle/serve entry plus a frame-level reference game driven by paddle bots.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pong_game_ctrl;

    logic CLK     = 1'b0;
    logic RST_BTN = 1'b0;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .CLK     (CLK),
        .RST_BTN (RST_BTN),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        int    st, bx, by, pl, pr, sl, sr;
    } exp_t;

    typedef struct {
        string name;
        bit    fr, st, lu, ld, ru, rd;
        int    est, ebx, eby, epl, epr, esl, esr;
    } vec_t;

    exp_t sb[$];
    vec_t vt[8];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference game state, advanced once per frame strobe.
    int m_state, m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_cnt;
    bit m_right, m_down;

    task automatic model_reset();
        m_state = 0; m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
        m_sl = 0; m_sr = 0; m_cnt = 0; m_right = 1; m_down = 1;
    endtask

    function automatic int pad_mv(int y, bit up, bit dn);
        if (up && !dn) return (y < 4) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
        return y;
    endfunction

    task automatic model_step(bit st, bit lu, bit ld, bit ru, bit rd);
        int  ny, opl, opr;
        bit  ndn, hl, hr;
        opl = m_pl;
        opr = m_pr;
        if (m_state == 0 || m_state == 3) begin
            if (st) begin
                m_state = 1; m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236;
                m_pl = 208; m_pr = 208; m_cnt = 60;
            end
        end else if (m_state == 1) begin
            m_pl = pad_mv(opl, lu, ld);
            m_pr = pad_mv(opr, ru, rd);
            if (m_cnt > 0) m_cnt--; else m_state = 2;
        end else begin
            if (!m_down && m_by < 2)          begin ny = 0;   ndn = 1; end
            else if (m_down && m_by > 470)    begin ny = 472; ndn = 0; end
            else begin ny = m_down ? m_by + 2 : m_by - 2; ndn = m_down; end
            hl = !m_right && m_bx >= 24 && m_bx < 26 && m_by + 8 > opl && m_by < opl + 64;
            hr = m_right && m_bx <= 608 && m_bx > 606 && m_by + 8 > opr && m_by < opr + 64;
            if (hl) begin
                m_bx = 24; m_right = 1; m_by = ny; m_down = ndn;
            end else if (hr) begin
                m_bx = 608; m_right = 0; m_by = ny; m_down = ndn;
            end else if (!m_right && m_bx < 2) begin
                m_sr++; m_bx = 316; m_by = 236; m_right = 0; m_cnt = 60;
                m_state = (m_sr == 9) ? 3 : 1;
            end else if (m_right && m_bx > 630) begin
                m_sl++; m_bx = 316; m_by = 236; m_right = 1; m_cnt = 60;
                m_state = (m_sl == 9) ? 3 : 1;
            end else begin
                m_bx = m_right ? m_bx + 2 : m_bx - 2; m_by = ny; m_down = ndn;
            end
            m_pl = pad_mv(opl, lu, ld);
            m_pr = pad_mv(opr, ru, rd);
        end
    endtask

    function automatic exp_t mexp(string n);
        exp_t e;
        e.name = n; e.st = m_state; e.bx = m_bx; e.by = m_by;
        e.pl = m_pl; e.pr = m_pr; e.sl = m_sl; e.sr = m_sr;
        return e;
    endfunction

    function automatic exp_t lit(string n, int st, int bx, int by, int pl, int pr,
                                 int sl, int sr);
        exp_t e;
        e.name = n; e.st = st; e.bx = bx; e.by = by;
        e.pl = pl; e.pr = pr; e.sl = sl; e.sr = sr;
        return e;
    endfunction

    task automatic check_now(exp_t e);
        bit ok;
        n_tests++;
        ok = (int'(bus.o_state) == e.st) && (int'(bus.o_ball_x) == e.bx)
          && (int'(bus.o_ball_y) == e.by) && (int'(bus.o_pad_l_y) == e.pl)
          && (int'(bus.o_pad_r_y) == e.pr) && (int'(bus.o_score_l) == e.sl)
          && (int'(bus.o_score_r) == e.sr) && (bus.o_game_over === (e.st == 3));
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got st=%0d ball=(%0d,%0d) pads=%0d/%0d score=%0d:%0d go=%0b, want st=%0d ball=(%0d,%0d) pads=%0d/%0d score=%0d:%0d go=%0b",
                     e.name, bus.o_state, bus.o_ball_x, bus.o_ball_y, bus.o_pad_l_y,
                     bus.o_pad_r_y, bus.o_score_l, bus.o_score_r, bus.o_game_over,
                     e.st, e.bx, e.by, e.pl, e.pr, e.sl, e.sr, (e.st == 3));
        end
    endtask

    // One cycle of stimulus; the expected outputs queue up at the edge and are
    // checked 1 time unit later, once the registers have settled.
    task automatic frame(bit fr, bit st, bit lu, bit ld, bit ru, bit rd, exp_t e);
        exp_t got;
        @(negedge CLK);
        bus.i_frame = fr; bus.i_start = st;
        bus.i_l_up = lu; bus.i_l_dn = ld; bus.i_r_up = ru; bus.i_r_dn = rd;
        @(posedge CLK);
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        check_now(got);
        @(negedge CLK);
        bus.i_frame = 1'b0;
    endtask

    task automatic play_frame(string n, bit st, bit lu, bit ld, bit ru, bit rd);
        model_step(st, lu, ld, ru, rd);
        frame(1'b1, st, lu, ld, ru, rd, mexp(n));
    endtask

    // Bot returning {up,dn} that keeps the paddle centred on the ball.
    function automatic bit [1:0] track(int pad, int by);
        if (pad + 32 < by + 2) return 2'b01;
        if (pad + 32 > by + 6) return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bit [1:0] cl, cr;
        int       guard;
        bus.i_frame = 0; bus.i_start = 0;
        bus.i_l_up = 0; bus.i_l_dn = 0; bus.i_r_up = 0; bus.i_r_dn = 0;

        vt[0] = '{"idle_noframe", 0, 1, 0, 0, 0, 0, 0, 316, 236, 208, 208, 0, 0};
        vt[1] = '{"idle_frame_lup", 1, 0, 1, 0, 0, 0, 0, 316, 236, 208, 208, 0, 0};
        vt[2] = '{"idle_frame_rdn", 1, 0, 0, 0, 0, 1, 0, 316, 236, 208, 208, 0, 0};
        vt[3] = '{"start_to_serve", 1, 1, 0, 0, 0, 0, 1, 316, 236, 208, 208, 0, 0};
        vt[4] = '{"serve_l_up", 1, 0, 1, 0, 0, 0, 1, 316, 236, 204, 208, 0, 0};
        vt[5] = '{"serve_r_dn", 1, 0, 0, 0, 0, 1, 1, 316, 236, 204, 212, 0, 0};
        vt[6] = '{"serve_both_hold", 1, 0, 1, 1, 1, 1, 1, 316, 236, 204, 212, 0, 0};
        vt[7] = '{"serve_noframe", 0, 0, 0, 1, 0, 0, 1, 316, 236, 204, 212, 0, 0};

        repeat (3) @(posedge CLK);
        #1;
        check_now(lit("reset_async", 0, 316, 236, 208, 208, 0, 0));
        @(negedge CLK);
        RST_BTN = 1'b1;
        model_reset();

        for (int i = 0; i < 8; i++) begin
            if (vt[i].fr) model_step(vt[i].st, vt[i].lu, vt[i].ld, vt[i].ru, vt[i].rd);
            frame(vt[i].fr, vt[i].st, vt[i].lu, vt[i].ld, vt[i].ru, vt[i].rd,
                  lit(vt[i].name, vt[i].est, vt[i].ebx, vt[i].eby, vt[i].epl,
                      vt[i].epr, vt[i].esl, vt[i].esr));
        end

        // Four serve frames consumed so far (entry plus three); 57 more hold.
        for (int i = 1; i < 57; i++) play_frame("serve_hold", 0, 0, 0, 0, 0);
        model_step(0, 0, 0, 0, 0);
        frame(1, 0, 0, 0, 0, 0, lit("serve_last", 1, 316, 236, 204, 212, 0, 0));
        model_step(0, 0, 0, 0, 0);
        frame(1, 0, 0, 0, 0, 0, lit("serve_to_play", 2, 316, 236, 204, 212, 0, 0));
        model_step(0, 0, 0, 0, 0);
        frame(1, 0, 0, 0, 0, 0, lit("play_first_step", 2, 318, 238, 204, 212, 0, 0));
        frame(0, 0, 1, 0, 1, 0, lit("play_noframe", 2, 318, 238, 204, 212, 0, 0));

        // Left paddle parked at the top until the right player scores.
        guard = 0;
        while (m_sr == 0 && guard < 4000) begin
            cr = track(m_pr, m_by);
            play_frame("rally_left_parked", 0, 1, 0, cr[1], cr[0]);
            guard++;
        end
        if (m_sr == 0) begin
            n_tests++; n_fail++;
            $display("FAIL right_score_budget: got score_r=%0d after %0d frames, want 1",
                     bus.o_score_r, guard);
        end

        // Left tracks, right dodges; the match runs to completion.
        guard = 0;
        while (m_state != 3 && guard < 16000) begin
            cl = track(m_pl, m_by);
            cr = (m_by + 4 >= 240) ? 2'b10 : 2'b01;
            play_frame("match", 0, cl[1], cl[0], cr[1], cr[0]);
            guard++;
        end
        if (m_state != 3) begin
            n_tests++; n_fail++;
            $display("FAIL match_budget: got state=%0d after %0d frames, want 3",
                     bus.o_state, guard);
        end

        play_frame("over_frozen", 0, 1, 0, 0, 1);
        play_frame("over_frozen2", 0, 0, 1, 1, 0);
        model_step(1, 0, 0, 0, 0);
        frame(1, 1, 0, 0, 0, 0, lit("restart_from_over", 1, 316, 236, 208, 208, 0, 0));

        for (int i = 0; i < 66; i++) play_frame("second_match", 0, 0, 1, 1, 0);

        @(negedge CLK);
        #2;
        RST_BTN = 1'b0;
        #1;
        check_now(lit("reset_mid_game", 0, 316, 236, 208, 208, 0, 0));
        model_reset();
        @(negedge CLK);
        RST_BTN = 1'b1;
        play_frame("idle_after_reset", 0, 1, 0, 1, 0);
        model_step(1, 0, 0, 0, 0);
        frame(1, 1, 0, 0, 0, 0, lit("start_after_reset", 1, 316, 236, 208, 208, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
